// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one pipelined multiplier, with owner tracking to route products back
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ELEMENT_WIDTH = 32,
  parameter int MULT_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ELEMENT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ELEMENT_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [ELEMENT_WIDTH-1:0]         mult_a,
  output logic [ELEMENT_WIDTH-1:0]         mult_b,
  output logic                             mult_t,
  input  logic [ELEMENT_WIDTH-1:0]         mult_p,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [ELEMENT_WIDTH-1:0]         resp_data
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] rr_ptr, sel, nxt_ptr;
  logic any, gnt, rv;
  logic [MULT_LATENCY-1:0] pipe_v;
  logic [IW-1:0] pipe_i [MULT_LATENCY];
  // scan downward so the candidate closest to rr_ptr is the one that sticks
  always_comb begin
    sel = rr_ptr;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        sel = IW'((int'(rr_ptr) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
  end
  always_comb begin
    nxt_ptr = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    gnt = any && !rst;
    req_grant = gnt ? NUM_REQ'(1) << sel : '0;
    mult_t = gnt;
    mult_a = gnt ? req_a[sel*ELEMENT_WIDTH +: ELEMENT_WIDTH] : '0;
    mult_b = gnt ? req_b[sel*ELEMENT_WIDTH +: ELEMENT_WIDTH] : '0;
    rv = pipe_v[MULT_LATENCY-1] && !rst;
    resp_valid = rv ? NUM_REQ'(1) << pipe_i[MULT_LATENCY-1] : '0;
    resp_data = rv ? mult_p : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      pipe_v <= '0;
    end else begin
      rr_ptr <= any ? nxt_ptr : rr_ptr;
      pipe_v[0] <= any;
      for (int k = 1; k < MULT_LATENCY; k++) pipe_v[k] <= pipe_v[k-1];
    end
    pipe_i[0] <= sel;
    for (int k = 1; k < MULT_LATENCY; k++) pipe_i[k] <= pipe_i[k-1];
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed and random traffic checked against a transaction-level scoreboard
module tb_mult_share_arbiter;
  localparam int N = 4, W = 32, L = 2, L5 = 5;
  typedef struct { int due; int idx; logic [W-1:0] p; } rsp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N-1:0] gnt, rv, gnt5, rv5;
  logic [W-1:0] ma, mb, mp, rd, ma5, mb5, mp5, rd5;
  logic mt, mt5;
  logic [W-1:0] pp [L];
  logic [W-1:0] pp5 [L5];
  rsp_t q2[$], q5[$];
  int n_tests = 0, n_fail = 0, cyc_n = 0, m_ptr = 0, last = -1;
  int wait_c [N];
  always #5 clk = ~clk;
  mult_share_arbiter #(.NUM_REQ(N), .ELEMENT_WIDTH(W), .MULT_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_grant(gnt), .mult_a(ma), .mult_b(mb), .mult_t(mt), .mult_p(mp),
    .resp_valid(rv), .resp_data(rd));
  mult_share_arbiter #(.NUM_REQ(N), .ELEMENT_WIDTH(W), .MULT_LATENCY(L5)) dut5 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_grant(gnt5), .mult_a(ma5), .mult_b(mb5), .mult_t(mt5), .mult_p(mp5),
    .resp_valid(rv5), .resp_data(rd5));
  // behavioural pipelined multipliers feeding each instance
  always @(posedge clk) begin
    pp[0] <= ma * mb;
    for (int k = 1; k < L; k++) pp[k] <= pp[k-1];
  end
  always @(posedge clk) begin
    pp5[0] <= ma5 * mb5;
    for (int k = 1; k < L5; k++) pp5[k] <= pp5[k-1];
  end
  assign mp = pp[L-1];
  assign mp5 = pp5[L5-1];
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask
  task automatic set_op(input int i);
    req_a[i*W +: W] = $urandom;
    req_b[i*W +: W] = $urandom;
  endtask
  task automatic cyc();
    int g;
    logic [N-1:0] eg, ev;
    logic [W-1:0] ea, eb, ed, pr;
    #1;
    g = -1;
    if (!rst) for (int k = N - 1; k >= 0; k--) if (req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    eg = '0; ea = '0; eb = '0;
    if (g >= 0) begin
      eg = N'(1) << g;
      ea = req_a[g*W +: W];
      eb = req_b[g*W +: W];
    end
    pr = ea * eb;
    chk("req_grant", W'(gnt), W'(eg));
    chk("mult_t", W'(mt), W'(g >= 0));
    chk("mult_a", ma, ea);
    chk("mult_b", mb, eb);
    chk("req_grant_l5", W'(gnt5), W'(eg));
    ev = '0; ed = '0;
    if (!rst && q2.size() > 0 && q2[0].due == cyc_n) begin
      ev = N'(1) << q2[0].idx; ed = q2[0].p; void'(q2.pop_front());
    end
    chk("resp_valid", W'(rv), W'(ev));
    chk("resp_data", rd, ed);
    ev = '0; ed = '0;
    if (!rst && q5.size() > 0 && q5[0].due == cyc_n) begin
      ev = N'(1) << q5[0].idx; ed = q5[0].p; void'(q5.pop_front());
    end
    chk("resp_valid_l5", W'(rv5), W'(ev));
    chk("resp_data_l5", rd5, ed);
    for (int i = 0; i < N; i++) begin
      if (rst || !req_valid[i] || gnt[i]) wait_c[i] = 0;
      else begin
        wait_c[i]++;
        chk("starvation", W'(wait_c[i] < N), W'(1));
      end
    end
    if (rst) begin
      q2.delete(); q5.delete(); m_ptr = 0;
    end else if (g >= 0) begin
      q2.push_back('{cyc_n + L, g, pr});
      q5.push_back('{cyc_n + L5, g, pr});
      m_ptr = (g + 1) % N;
    end
    last = g;
    @(posedge clk);
    cyc_n++;
    #1;
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin wait_c[i] = 0; set_op(i); end
    @(posedge clk); #1;
    req_valid = 4'b1111;
    cyc(); cyc();
    rst = 1'b0; req_valid = 4'b0100;
    req_a[2*W +: W] = 32'd7; req_b[2*W +: W] = 32'd6;
    cyc();
    req_valid = '0;
    repeat (3) cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; req_valid = 4'b1111;
    repeat (14) begin cyc(); if (last >= 0) set_op(last); end
    req_valid = '0; repeat (6) cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; req_valid = 4'b0010; cyc(); set_op(1);
    req_valid = 4'b1010;
    repeat (8) begin cyc(); if (last >= 0) set_op(last); end
    req_valid = 4'b0001;
    repeat (5) begin cyc(); set_op(0); end
    req_valid = '0; repeat (6) cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; req_valid = 4'b0011; cyc(); cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; req_valid = '0; repeat (6) cyc();
    req_valid = 4'b1111; cyc(); set_op(0);
    req_valid = 4'b1100; cyc();
    req_valid = '0; repeat (6) cyc();
    repeat (10000) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last == i) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_op(i);
        end
      end
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0; req_valid = '0;
    repeat (6) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
